// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch control: drives the IT RAM read and the next PC,
// buffers returned words in a 2-entry FIFO towards decode.
module if_fetch_ctrl #(
  parameter int unsigned XLEN = 32,
  parameter logic [XLEN-1:0] BOOT_IT_ADDR = '0,
  parameter int unsigned IT_RAM_DEPTH = 4096,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_addr,
  output logic            pc_write_en,
  output logic [XLEN-1:0] pc_write_addr,
  output logic            ram_rd_en,
  output logic [XLEN-1:0] ram_rd_addr,
  input  logic [31:0]     ram_rd_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_addr,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [31:0]     id_inst,
  output logic [XLEN-1:0] id_pc,
  output logic            fetch_fault
);

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  typedef struct packed {
    logic [31:0]     inst;
    logic [XLEN-1:0] pc;
  } ent_t;

  localparam logic [XLEN:0] LO = {1'b0, BOOT_IT_ADDR};
  localparam logic [XLEN:0] HI =
    LO + (XLEN+1)'(IT_RAM_DEPTH);
  localparam logic [2:0] BUF_N = 3'(BUF_DEPTH);

  function automatic logic legal(
    input logic [XLEN-1:0] a
  );
    logic [XLEN:0] w;
    w = {1'b0, a};
    return (w >= LO) && (w < HI) &&
           (a[1:0] == 2'b00);
  endfunction

  state_t          state;
  state_t          state_nx;
  logic            fault;
  logic            fault_nx;
  logic [1:0]      count;
  logic            inflight;
  logic [XLEN-1:0] infl_pc;
  ent_t            ent0;
  ent_t            ent1;
  ent_t            in_ent;

  logic            head_vld;
  logic            pop;
  logic            push;
  logic [2:0]      occ;
  logic            room;
  logic [XLEN:0]   seq_w;
  logic [XLEN-1:0] seq;
  logic            seq_ok;
  logic            issue;
  logic            wr_en;
  logic [XLEN-1:0] wr_addr;

  assign head_vld = (count != 2'd0);
  assign pop      = head_vld && id_ready;
  // A killed or flushed read never lands
  assign push     = inflight && !redirect_valid;
  assign in_ent   = '{inst: ram_rd_data,
                      pc:   infl_pc};

  // Issue only when the returning word is sure to fit
  assign occ  = 3'(count) + 3'(inflight);
  assign room = (occ < BUF_N) ||
                ((occ == BUF_N) && pop);

  // Carry out of pc+4 marks a wrapped, illegal address
  assign seq_w  = {1'b0, pc_addr} + (XLEN+1)'(4);
  assign seq    = seq_w[XLEN-1:0];
  assign seq_ok = !seq_w[XLEN] && legal(seq);

  always_comb begin
    state_nx = state;
    fault_nx = fault;
    issue    = 1'b0;
    wr_en    = 1'b0;
    wr_addr  = '0;
    unique case (1'b1)
      redirect_valid: begin
        if (legal(redirect_addr)) begin
          wr_en    = 1'b1;
          wr_addr  = redirect_addr;
          state_nx = RUN;
          fault_nx = 1'b0;
        end else begin
          state_nx = HALT;
          fault_nx = 1'b1;
        end
      end
      (!redirect_valid && state == RUN && room): begin
        issue = 1'b1;
        if (seq_ok) begin
          wr_en   = 1'b1;
          wr_addr = seq;
        end else begin
          state_nx = HALT;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= RUN;
      fault    <= 1'b0;
      inflight <= 1'b0;
      infl_pc  <= '0;
    end else begin
      state    <= state_nx;
      fault    <= fault_nx;
      inflight <= issue;
      if (issue) infl_pc <= pc_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= 2'd0;
      ent0  <= '0;
      ent1  <= '0;
    end else if (redirect_valid) begin
      count <= 2'd0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (count == 2'd0) ent0 <= in_ent;
          else               ent1 <= in_ent;
          count <= count + 2'd1;
        end
        2'b01: begin
          ent0  <= ent1;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            ent0 <= in_ent;
          end else begin
            ent0 <= ent1;
            ent1 <= in_ent;
          end
        end
        default: ;
      endcase
    end
  end

  // Every output is held at zero while reset is asserted
  assign pc_write_en   = rst && wr_en;
  assign pc_write_addr = rst ? wr_addr : '0;
  assign ram_rd_en     = rst && issue;
  assign ram_rd_addr   = (rst && issue) ? pc_addr : '0;
  assign id_valid      = rst && head_vld;
  assign id_inst       = (rst && head_vld) ? ent0.inst : '0;
  assign id_pc         = (rst && head_vld) ? ent0.pc : '0;
  assign fetch_fault   = rst && fault;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Bench for if_fetch_ctrl: PC register + IT RAM environment,
// queue-based reference model checked every cycle, directed phases.
module tb_if_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_addr;
  logic        pc_write_en;
  logic [31:0] pc_write_addr;
  logic        ram_rd_en;
  logic [31:0] ram_rd_addr;
  logic [31:0] ram_rd_data;
  logic        redirect_valid;
  logic [31:0] redirect_addr;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic        fetch_fault;

  if_fetch_ctrl dut (
    .clk(clk), .rst(rst),
    .pc_addr(pc_addr),
    .pc_write_en(pc_write_en),
    .pc_write_addr(pc_write_addr),
    .ram_rd_en(ram_rd_en),
    .ram_rd_addr(ram_rd_addr),
    .ram_rd_data(ram_rd_data),
    .redirect_valid(redirect_valid),
    .redirect_addr(redirect_addr),
    .id_valid(id_valid),
    .id_ready(id_ready),
    .id_inst(id_inst),
    .id_pc(id_pc),
    .fetch_fault(fetch_fault)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  function automatic bit legal(input logic [31:0] a);
    return (a < 32'h1000) && (a[1:0] == 2'b00);
  endfunction

  // PC register (drops illegal writes) and IT RAM (word = address)
  logic [31:0] pc_rst_val = 32'h0;
  logic [31:0] pc_reg = 32'h0;
  assign pc_addr = pc_reg;
  always @(posedge clk) begin
    if (!rst) pc_reg <= pc_rst_val;
    else if (pc_write_en && legal(pc_write_addr))
      pc_reg <= pc_write_addr;
    ram_rd_data <= ram_rd_en ? ram_rd_addr : 32'hDEAD_BEEF;
  end

  // Reference model: FIFO of PCs, one optional read in flight
  logic [31:0] q[$];
  bit          m_infl = 0;
  logic [31:0] m_infl_pc = 0;
  bit          m_halt = 0;
  bit          m_fault = 0;
  bit          d_pop, d_issue, d_seq_ok;
  logic [31:0] d_issue_pc;

  logic [31:0] got[$];
  bit          saw_1000 = 0;
  logic        s_valid, s_rd_en, s_wr_en, s_fault;
  logic [31:0] s_pc, s_inst, s_rd_addr, s_wr_addr;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s got=%h want=%h t=%0t",
               nm, act, exp, $time);
    else
      passed++;
  endtask

  task automatic check_cycle();
    bit ev, eiss, ewr, ef;
    logic [31:0] epc, ewa;
    ev = 0; eiss = 0; ewr = 0; ef = 0;
    epc = 0; ewa = 0;
    d_pop = 0; d_issue = 0; d_seq_ok = 0;
    d_issue_pc = pc_addr;
    if (rst) begin
      ev = (q.size() != 0);
      if (ev) epc = q[0];
      ef = m_fault;
      d_pop = ev && id_ready;
      if (redirect_valid) begin
        ewr = legal(redirect_addr);
        ewa = redirect_addr;
      end else if (!m_halt &&
          (q.size() + int'(m_infl) - int'(d_pop)) <= 1) begin
        eiss = 1;
        d_seq_ok = (pc_addr <= 32'hFFFF_FFFB) &&
                   legal(pc_addr + 32'd4);
        ewr = d_seq_ok;
        ewa = pc_addr + 32'd4;
      end
      d_issue = eiss;
    end
    chk("id_valid", id_valid, ev);
    chk("fetch_fault", fetch_fault, ef);
    chk("ram_rd_en", ram_rd_en, eiss);
    chk("pc_write_en", pc_write_en, ewr);
    if (!rst) begin
      chk("rst_id_pc", id_pc, 0);
      chk("rst_id_inst", id_inst, 0);
      chk("rst_rd_addr", ram_rd_addr, 0);
      chk("rst_wr_addr", pc_write_addr, 0);
    end else begin
      if (ev) begin
        chk("id_pc", id_pc, epc);
        chk("id_inst", id_inst, epc);
      end
      if (eiss) chk("ram_rd_addr", ram_rd_addr, pc_addr);
      if (ewr) chk("pc_write_addr", pc_write_addr, ewa);
    end
    if (rst && id_valid && id_ready) got.push_back(id_pc);
    if (ram_rd_en && ram_rd_addr == 32'h1000) saw_1000 = 1;
    s_valid = id_valid; s_pc = id_pc; s_inst = id_inst;
    s_rd_en = ram_rd_en; s_rd_addr = ram_rd_addr;
    s_wr_en = pc_write_en; s_wr_addr = pc_write_addr;
    s_fault = fetch_fault;
  endtask

  task automatic model_step();
    if (!rst) begin
      q.delete();
      m_infl = 0; m_halt = 0; m_fault = 0;
    end else if (redirect_valid) begin
      q.delete();
      m_infl  = 0;
      m_halt  = !legal(redirect_addr);
      m_fault = !legal(redirect_addr);
    end else begin
      if (d_pop) void'(q.pop_front());
      if (m_infl) q.push_back(m_infl_pc);
      m_infl = d_issue;
      m_infl_pc = d_issue_pc;
      if (d_issue && !d_seq_ok) m_halt = 1;
    end
  endtask

  task automatic tick(input bit r, input bit rdy,
                      input bit rv, input logic [31:0] ra);
    @(negedge clk);
    rst = r; id_ready = rdy;
    redirect_valid = rv; redirect_addr = ra;
    #1;
    check_cycle();
    @(posedge clk);
    model_step();
  endtask

  int idx;

  initial begin
    rst = 0; id_ready = 0;
    redirect_valid = 0; redirect_addr = 0;
    tick(0, 0, 0, 0);
    tick(0, 1, 0, 0);
    chk("reset_valid", s_valid, 0);
    chk("reset_wr_en", s_wr_en, 0);

    // Stream from address 0, valid two cycles after release
    tick(1, 1, 0, 0);
    chk("a0_rd_en", s_rd_en, 1);
    chk("a0_rd_addr", s_rd_addr, 0);
    chk("a0_valid", s_valid, 0);
    tick(1, 1, 0, 0);
    chk("a1_valid", s_valid, 0);
    tick(1, 1, 0, 0);
    chk("a2_valid", s_valid, 1);
    chk("a2_pc", s_pc, 0);
    tick(1, 1, 0, 0);
    tick(1, 1, 0, 0);

    // Backpressure four cycles: head holds at 12
    for (int i = 0; i < 4; i++) begin
      tick(1, 0, 0, 0);
      chk("bp_rd_en", s_rd_en, 0);
      chk("bp_hold_pc", s_pc, 32'd12);
    end
    tick(1, 1, 0, 0);
    chk("bp_resume_rd", s_rd_en, 1);
    chk("bp_resume_addr", s_rd_addr, 32'd20);
    for (int i = 0; i < 5; i++) tick(1, 1, 0, 0);
    chk("stream_len", got.size(), 9);
    for (int i = 0; i < got.size(); i++)
      chk("stream_seq", got[i], 32'(4 * i));

    // Redirect with an entry buffered and a read in flight
    tick(1, 1, 1, 32'h100);
    chk("rd_wr_en", s_wr_en, 1);
    chk("rd_wr_addr", s_wr_addr, 32'h100);
    chk("rd_no_read", s_rd_en, 0);
    idx = got.size();
    tick(1, 1, 0, 0);
    chk("rd_flushed", s_valid, 0);
    chk("rd_first_addr", s_rd_addr, 32'h100);
    for (int i = 0; i < 5; i++) tick(1, 1, 0, 0);
    chk("rd_count", got.size(), idx + 4);
    chk("rd_first_pc", got[idx], 32'h100);
    chk("rd_second_pc", got[idx + 1], 32'h104);

    // Illegal redirects fault and stop fetch; legal one recovers
    for (int i = 0; i < 3; i++) tick(1, 0, 0, 0);
    tick(1, 0, 1, 32'h2000);
    chk("f1_wr_en", s_wr_en, 0);
    tick(1, 1, 0, 0);
    chk("f1_fault", s_fault, 1);
    chk("f1_valid", s_valid, 0);
    tick(1, 1, 0, 0);
    chk("f1_no_read", s_rd_en, 0);
    tick(1, 1, 1, 32'h102);
    chk("f2_wr_en", s_wr_en, 0);
    tick(1, 1, 0, 0);
    chk("f2_fault", s_fault, 1);
    idx = got.size();
    tick(1, 1, 1, 32'h40);
    chk("f3_wr_addr", s_wr_addr, 32'h40);
    tick(1, 1, 0, 0);
    chk("f3_fault_clr", s_fault, 0);
    chk("f3_rd_addr", s_rd_addr, 32'h40);
    for (int i = 0; i < 3; i++) tick(1, 1, 0, 0);
    chk("f3_first_pc", got[idx], 32'h40);

    // Run off the top of the IT RAM
    tick(1, 1, 1, 32'hFF0);
    for (int i = 0; i < 4; i++) tick(1, 1, 0, 0);
    chk("end_rd_addr", s_rd_addr, 32'hFFC);
    chk("end_wr_en", s_wr_en, 0);
    for (int i = 0; i < 4; i++) tick(1, 1, 0, 0);
    chk("end_last_pc", got[got.size() - 1], 32'hFFC);
    chk("end_no_1000", saw_1000, 0);
    chk("end_no_fault", s_fault, 0);
    chk("end_idle", s_rd_en, 0);

    // Mid-stream reset, PC register comes back at 0x200
    tick(1, 1, 1, 32'h300);
    for (int i = 0; i < 4; i++) tick(1, 1, 0, 0);
    pc_rst_val = 32'h200;
    tick(0, 1, 0, 0);
    chk("mr_valid", s_valid, 0);
    chk("mr_pc", s_pc, 0);
    chk("mr_rd_en", s_rd_en, 0);
    idx = got.size();
    tick(1, 1, 0, 0);
    chk("mr_rd_addr", s_rd_addr, 32'h200);
    tick(1, 1, 0, 0);
    tick(1, 1, 0, 0);
    chk("mr_first_pc", s_pc, 32'h200);
    tick(1, 1, 0, 0);
    chk("mr_log_pc", got[idx], 32'h200);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
